// File: rtl/tm_sch_event_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tm_sch_event_ctrl_pkg                                                |
// | Shared widths and FSM encoding for the scheduler event control stage |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tm_sch_event_ctrl_pkg;

  localparam int unsigned c_SCH_ID_NBITS_DFLT = 4;
  localparam int unsigned c_CNT_NBITS_DFLT    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tm_sch_event_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tm_sch_event_ctrl_if                                                 |
// | Enqueue, event-FIFO and dequeue signals of the event control stage   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tm_sch_event_ctrl_if
  import tm_sch_event_ctrl_pkg::*;
#(
  parameter int unsigned SCH_ID_NBITS = c_SCH_ID_NBITS_DFLT
) ();

  logic                    enq_valid;
  logic [SCH_ID_NBITS-1:0] enq_sch_id;
  logic                    enq_ready;
  logic                    ev_push;
  logic [SCH_ID_NBITS-1:0] ev_push_data;
  logic                    ev_pop;
  logic [SCH_ID_NBITS-1:0] ev_pop_data;
  logic                    ev_empty;
  logic                    deq_valid;
  logic [SCH_ID_NBITS-1:0] deq_sch_id;
  logic                    deq_ack;
  logic                    backlog_err;

  modport slave (
    input  enq_valid, enq_sch_id, ev_pop_data, ev_empty, deq_ack,
    output enq_ready, ev_push, ev_push_data, ev_pop, deq_valid, deq_sch_id, backlog_err
  );

  modport master (
    output enq_valid, enq_sch_id, ev_pop_data, ev_empty, deq_ack,
    input  enq_ready, ev_push, ev_push_data, ev_pop, deq_valid, deq_sch_id, backlog_err
  );

endinterface
`default_nettype wire

// File: rtl/tm_sch_backlog_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tm_sch_backlog_cnt                                                   |
// | Per-ID backlog counters with one increment and one decrement port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tm_sch_backlog_cnt
  import tm_sch_event_ctrl_pkg::*;
#(
  parameter int unsigned SCH_ID_NBITS = c_SCH_ID_NBITS_DFLT,
  parameter int unsigned CNT_NBITS    = c_CNT_NBITS_DFLT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_i,
  input  logic [SCH_ID_NBITS-1:0] inc_id_i,
  input  logic                    dec_i,
  input  logic [SCH_ID_NBITS-1:0] dec_id_i,
  input  logic [SCH_ID_NBITS-1:0] rd_a_id_i,
  output logic [CNT_NBITS-1:0]    rd_a_o,
  input  logic [SCH_ID_NBITS-1:0] rd_b_id_i,
  output logic [CNT_NBITS-1:0]    rd_b_o
);

  localparam int                   NUM_SCH = 1 << SCH_ID_NBITS;
  localparam logic [CNT_NBITS-1:0] c_ONE   = CNT_NBITS'(1);

  logic [CNT_NBITS-1:0] cnt_q [NUM_SCH];
  logic [CNT_NBITS-1:0] cnt_d [NUM_SCH];

  // An increment and decrement hitting the same index cancel out.
  always_comb begin
    for (int i = 0; i < NUM_SCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_i && (inc_id_i == SCH_ID_NBITS'(i)) &&
          !(dec_i && (dec_id_i == SCH_ID_NBITS'(i)))) begin
        cnt_d[i] = cnt_q[i] + c_ONE;
      end else if (dec_i && (dec_id_i == SCH_ID_NBITS'(i)) &&
                   !(inc_i && (inc_id_i == SCH_ID_NBITS'(i)))) begin
        cnt_d[i] = cnt_q[i] - c_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_a_o = cnt_q[rd_a_id_i];
  assign rd_b_o = cnt_q[rd_b_id_i];

endmodule
`default_nettype wire

// File: rtl/tm_sch_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tm_sch_event_ctrl                                                    |
// | Backlog tracking and pop/issue/re-push control around the event FIFO |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tm_sch_event_ctrl
  import tm_sch_event_ctrl_pkg::*;
#(
  parameter int unsigned SCH_ID_NBITS = c_SCH_ID_NBITS_DFLT,
  parameter int unsigned CNT_NBITS    = c_CNT_NBITS_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tm_sch_event_ctrl_if.slave   bus
);

  localparam logic [CNT_NBITS-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_NBITS-1:0] c_CNT_ONE = CNT_NBITS'(1);

  state_e                  state_q, state_d;
  logic [SCH_ID_NBITS-1:0] cur_id_q, cur_id_d;
  logic                    err_q, err_d;
  logic [CNT_NBITS-1:0]    enq_cnt, cur_cnt;
  logic                    enq_rdy, enq_fire, dec;
  logic                    push, pop, dq_valid;
  logic [SCH_ID_NBITS-1:0] push_id;

  tm_sch_backlog_cnt #(
    .SCH_ID_NBITS (SCH_ID_NBITS),
    .CNT_NBITS    (CNT_NBITS)
  ) u_backlog (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (enq_fire),
    .inc_id_i  (bus.enq_sch_id),
    .dec_i     (dec),
    .dec_id_i  (cur_id_q),
    .rd_a_id_i (bus.enq_sch_id),
    .rd_a_o    (enq_cnt),
    .rd_b_id_i (cur_id_q),
    .rd_b_o    (cur_cnt)
  );

  // RETIRE owns the FIFO push port, so enqueues stall for that cycle.
  assign enq_rdy  = rst_n && (state_q != ST_RETIRE) && (enq_cnt != c_CNT_MAX);
  assign enq_fire = bus.enq_valid && enq_rdy;
  assign err_d    = err_q || (bus.enq_valid && (enq_cnt == c_CNT_MAX));

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    pop      = 1'b0;
    dq_valid = 1'b0;
    dec      = 1'b0;
    push     = enq_fire && (enq_cnt == '0);
    push_id  = bus.enq_sch_id;
    unique case (state_q)
      ST_IDLE: begin
        if (rst_n && !bus.ev_empty) begin
          pop      = 1'b1;
          cur_id_d = bus.ev_pop_data;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dq_valid = 1'b1;
        if (bus.deq_ack) begin
          state_d = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        dec = 1'b1;
        if (cur_cnt != c_CNT_ONE) begin
          push    = 1'b1;
          push_id = cur_id_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      err_q    <= err_d;
    end
  end

  assign bus.enq_ready    = enq_rdy;
  assign bus.ev_push      = push;
  assign bus.ev_push_data = push_id;
  assign bus.ev_pop       = pop;
  assign bus.deq_valid    = dq_valid;
  assign bus.deq_sch_id   = cur_id_q;
  assign bus.backlog_err  = err_q;

  a_no_ack_without_valid: assert property (
    @(posedge clk) disable iff (!rst_n) bus.deq_ack |-> bus.deq_valid
  );

endmodule
`default_nettype wire
